accum_ctrl_gen: RTL and testbench

//  Initiator side of the MVU accumulator control interface. Takes one reduction instruction
//  (accumulator count, pass count) and drives the per-lane {valid, op, size} control words
//  to the BRAM accumulator, one per upstream dot-product beat. Sits between the MVU

---
 rtl/accum_ctrl_gen.sv | 125 ++++++++++++
 tb/tb_accum_ctrl_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/accum_ctrl_gen.sv
// accum_ctrl_gen: sequences SET/UPD/WB/SET_AND_WB ctrl words to the MVU accumulator.
// Ports: clk, rst (sync, high), inst_* handshake, beat_valid in; accum_ctrl, busy, done, err out.
module accum_ctrl_gen #(
  parameter int NDPE       = 2,
  parameter int NUM_ACCUM  = 8,
  parameter int ACCIDW     = 4,
  parameter int PASSW      = 16,
  parameter int CTRL_DELAY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           inst_valid,
  output logic                           inst_ready,
  input  logic [ACCIDW-1:0]              inst_size,
  input  logic [PASSW-1:0]               inst_passes,
  input  logic                           beat_valid,
  output logic [3*NDPE*(3+ACCIDW)-1:0]   accum_ctrl,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     err
);

  localparam int CW = 3 + ACCIDW;
  localparam logic [ACCIDW-1:0] ONE_A = 1;
  localparam logic [PASSW-1:0]  ONE_P = 1;
  localparam logic [ACCIDW-1:0] MAXS  = ACCIDW'(NUM_ACCUM);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;
  logic [ACCIDW-1:0] size_q, size_nx;
  logic [ACCIDW-1:0] addr_q, addr_nx;
  logic [PASSW-1:0]  passes_q, passes_nx;
  logic [PASSW-1:0]  pass_q, pass_nx;
  logic [1:0]        err_nx;
  logic [CW-1:0]     word;
  logic              done_src;
  logic              last_addr, last_pass, final_beat;
  logic              accept, illegal;
  logic [1:0]        op;

  // {done, ctrl word} delay line; last stage drives the outputs
  logic [CW:0] pipe [CTRL_DELAY];

  always_comb begin
    last_addr  = (addr_q == size_q - ONE_A);
    last_pass  = (pass_q == passes_q - ONE_P);
    final_beat = (state == RUN) && beat_valid && last_addr && last_pass;
    // the final beat frees the slot, so the next instruction has no bubble
    inst_ready = (state == IDLE) || final_beat;
    accept     = inst_valid && inst_ready;
    illegal    = (inst_size == '0) || (inst_size > MAXS) || (inst_passes == '0);
    if (passes_q == ONE_P)  op = 2'd3;
    else if (pass_q == '0)  op = 2'd0;
    else if (last_pass)     op = 2'd2;
    else                    op = 2'd1;
  end

  always_comb begin
    state_nx  = state;
    size_nx   = size_q;
    passes_nx = passes_q;
    addr_nx   = addr_q;
    pass_nx   = pass_q;
    err_nx    = err;
    word      = '0;
    done_src  = 1'b0;
    if (beat_valid) begin
      if (state == RUN) begin
        word = {1'b1, op, size_q};
        // address wraps on size, matching the accumulator's own wrap
        if (last_addr) begin
          addr_nx = '0;
          pass_nx = pass_q + ONE_P;
        end else begin
          addr_nx = addr_q + ONE_A;
        end
        if (final_beat) begin
          state_nx = IDLE;
          done_src = 1'b1;
        end
      end else begin
        err_nx[0] = 1'b1;
      end
    end
    if (accept) begin
      if (illegal) begin
        err_nx[1] = 1'b1;
        done_src  = 1'b1;
      end else begin
        size_nx   = inst_size;
        passes_nx = inst_passes;
        addr_nx   = '0;
        pass_nx   = '0;
        state_nx  = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      size_q   <= '0;
      passes_q <= '0;
      addr_q   <= '0;
      pass_q   <= '0;
      err      <= '0;
      for (int i = 0; i < CTRL_DELAY; i++) pipe[i] <= '0;
    end else begin
      state    <= state_nx;
      size_q   <= size_nx;
      passes_q <= passes_nx;
      addr_q   <= addr_nx;
      pass_q   <= pass_nx;
      err      <= err_nx;
      pipe[0]  <= {done_src, word};
      for (int i = 1; i < CTRL_DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign busy       = (state == RUN);
  assign done       = pipe[CTRL_DELAY-1][CW];
  assign accum_ctrl = {(3*NDPE){pipe[CTRL_DELAY-1][CW-1:0]}};

endmodule

// File: tb/tb_accum_ctrl_gen.sv
// tb_accum_ctrl_gen: random + directed bench, two DUTs (delay 1 and 3) vs a word-list model.
// Ports: none.
module tb_accum_ctrl_gen;

  localparam int NDPE = 2;
  localparam int NUM_ACCUM = 8;
  localparam int ACCIDW = 4;
  localparam int PASSW = 16;
  localparam int CW = 3 + ACCIDW;
  localparam int L = 3 * NDPE;
  localparam int AW = L * CW;

  logic clk, rst;
  logic inst_valid;
  logic [ACCIDW-1:0] inst_size;
  logic [PASSW-1:0] inst_passes;
  logic beat_valid;
  logic rdy1, rdy3, busy1, busy3, done1, done3;
  logic [1:0] err1, err3;
  logic [AW-1:0] ac1, ac3;

  accum_ctrl_gen #(.NDPE(NDPE), .NUM_ACCUM(NUM_ACCUM), .ACCIDW(ACCIDW),
    .PASSW(PASSW), .CTRL_DELAY(1)) u_d1 (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(rdy1),
    .inst_size(inst_size), .inst_passes(inst_passes), .beat_valid(beat_valid),
    .accum_ctrl(ac1), .busy(busy1), .done(done1), .err(err1));

  accum_ctrl_gen #(.NDPE(NDPE), .NUM_ACCUM(NUM_ACCUM), .ACCIDW(ACCIDW),
    .PASSW(PASSW), .CTRL_DELAY(3)) u_d3 (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(rdy3),
    .inst_size(inst_size), .inst_passes(inst_passes), .beat_valid(beat_valid),
    .accum_ctrl(ac3), .busy(busy3), .done(done3), .err(err3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // model: words still owed by the current instruction, and per-cycle output history
  logic [CW-1:0] rem[$];
  logic [CW-1:0] hist_w[$];
  logic          hist_d[$];
  logic [1:0]    m_err;
  bit            chk_en = 0;
  bit            last_acc;

  typedef struct {
    logic [ACCIDW-1:0] sz;
    logic [PASSW-1:0]  ps;
  } inst_t;
  inst_t pend[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] op_of(input int p, input int ps);
    if (ps == 1) return 2'd3;
    if (p == 0) return 2'd0;
    if (p == ps - 1) return 2'd2;
    return 2'd1;
  endfunction

  task automatic step(input logic iv, input logic [ACCIDW-1:0] sz,
                      input logic [PASSW-1:0] ps, input logic bv, input logic r);
    int k;
    logic rdy, d;
    logic [CW-1:0] w, e1, e3;
    logic d1, d3;
    inst_valid = iv;
    inst_size = sz;
    inst_passes = ps;
    beat_valid = bv;
    rst = r;
    @(negedge clk);
    rdy = (rem.size() == 0) || (bv && rem.size() == 1);
    if (chk_en) begin
      k = hist_w.size();
      e1 = (k >= 1) ? hist_w[k-1] : '0;
      d1 = (k >= 1) ? hist_d[k-1] : 1'b0;
      e3 = (k >= 3) ? hist_w[k-3] : '0;
      d3 = (k >= 3) ? hist_d[k-3] : 1'b0;
      chk("ready1", 64'(rdy1), 64'(rdy));
      chk("ready3", 64'(rdy3), 64'(rdy));
      chk("busy1", 64'(busy1), 64'(rem.size() > 0));
      chk("busy3", 64'(busy3), 64'(rem.size() > 0));
      chk("err1", 64'(err1), 64'(m_err));
      chk("err3", 64'(err3), 64'(m_err));
      chk("ctrl1", 64'(ac1), 64'({L{e1}}));
      chk("ctrl3", 64'(ac3), 64'({L{e3}}));
      chk("done1", 64'(done1), 64'(d1));
      chk("done3", 64'(done3), 64'(d3));
    end
    last_acc = 0;
    if (r) begin
      rem.delete();
      hist_w.delete();
      hist_d.delete();
      m_err = '0;
      chk_en = 1;
    end else begin
      w = '0;
      d = 1'b0;
      if (bv) begin
        if (rem.size() > 0) begin
          w = rem.pop_front();
          if (rem.size() == 0) d = 1'b1;
        end else begin
          m_err[0] = 1'b1;
        end
      end
      if (iv && rdy) begin
        last_acc = 1;
        if (sz == 0 || sz > NUM_ACCUM || ps == 0) begin
          m_err[1] = 1'b1;
          d = 1'b1;
        end else begin
          for (int p = 0; p < int'(ps); p++)
            for (int a = 0; a < int'(sz); a++)
              rem.push_back({1'b1, op_of(p, int'(ps)), sz});
        end
      end
      hist_w.push_back(w);
      hist_d.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // issues pend[] as fast as the model allows, beats at pct% while busy
  task automatic run(input int pct, input bit stray_ok, input int limit);
    int n = 0;
    logic bv, iv;
    inst_t f;
    while ((pend.size() > 0 || rem.size() > 0) && n < limit) begin
      iv = pend.size() > 0;
      f.sz = '0;
      f.ps = '0;
      if (iv) f = pend[0];
      if (rem.size() > 0) bv = ($urandom_range(99) < pct);
      else bv = stray_ok && ($urandom_range(99) < 20);
      step(iv, f.sz, f.ps, bv, 1'b0);
      if (last_acc) void'(pend.pop_front());
      n++;
    end
    chk("timeout", 64'(n >= limit), 64'(0));
    idle(4);
  endtask

  initial begin
    rst = 1'b1;
    inst_valid = 1'b0;
    inst_size = '0;
    inst_passes = '0;
    beat_valid = 1'b0;
    m_err = '0;
    #1;
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(2);
    // stray beat in IDLE
    step(1'b0, '0, '0, 1'b1, 1'b0);
    idle(3);
    pend.push_back('{4, 3});
    run(100, 0, 200);
    pend.push_back('{8, 1});
    run(100, 0, 200);
    pend.push_back('{8, 1});
    run(50, 0, 400);
    pend.push_back('{4, 2});
    pend.push_back('{2, 1});
    run(100, 0, 200);
    pend.push_back('{0, 3});
    pend.push_back('{4, 0});
    pend.push_back('{9, 1});
    pend.push_back('{3, 2});
    run(70, 0, 300);
    // reset in the middle of a (4,3) instruction
    step(1'b1, 4, 3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    pend.push_back('{4, 3});
    run(100, 0, 200);
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 8; i++) begin
        inst_t t;
        t.sz = ACCIDW'($urandom_range(10));
        t.ps = ($urandom_range(9) == 0) ? '0 : PASSW'($urandom_range(1, 4));
        pend.push_back(t);
      end
      run(int'($urandom_range(40, 100)), bit'(j % 2), 2000);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
